// File: rtl/eeg_loader_pkg.sv
// Shared types, memory map and number-format tables for the EEG input path.
// Also holds the loader FSM state type and the counter trigger modes.
package eeg_loader_pkg;

    localparam int PATCH_LEN   = 256;
    localparam int NUM_PATCHES = 15;

    typedef logic [15:0] AdcData_t;
    typedef logic [15:0] IntResAddr_t;
    typedef logic [29:0] IntResDouble_t;

    typedef enum logic {SINGLE_WIDTH, DOUBLE_WIDTH} DataWidth_t;
    typedef enum logic [1:0] {INT_RES_SW_FX, INT_RES_DW_FX, INT_RES_SW_INT} FxFormatIntRes_t;

    typedef enum logic [1:0] {EEG_INPUT_MEM, PATCH_EMB_MEM, ACTIVATION_MEM} MemRegion_t;
    localparam IntResAddr_t mem_map [3] = '{16'd0, 16'd4096, 16'd8192};

    typedef enum logic {EEG_FORMAT, EMB_FORMAT} FormatSel_t;
    localparam FxFormatIntRes_t int_res_format [2] = '{INT_RES_DW_FX, INT_RES_SW_FX};

    typedef enum logic [1:0] {IDLE, LOAD, DONE} EegLoaderState_t;

    typedef enum logic {POSEDGE_TRIGGERED, NEGEDGE_TRIGGERED} CounterMode_t;

    // An unsigned 16-bit ADC code becomes a non-negative fraction with 20 fractional bits.
    function automatic IntResDouble_t adc_to_int_res(input AdcData_t sample);
        return {10'b0, sample, 4'b0000};
    endfunction

endpackage

// File: rtl/eeg_loader_counter.sv
// Generic synchronous-clear up-counter; MODE selects which clock edge updates it.
module eeg_loader_counter
    import eeg_loader_pkg::*;
#(
    parameter int           WIDTH = 8,
    parameter CounterMode_t MODE  = POSEDGE_TRIGGERED
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr_i,
    input  logic             inc_i,
    output logic [WIDTH-1:0] cnt_o
);

    logic [WIDTH-1:0] cnt_q;
    logic [WIDTH-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    generate
        if (MODE == POSEDGE_TRIGGERED) begin : g_pos
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    cnt_q <= '0;
                end else begin
                    cnt_q <= cnt_d;
                end
            end
        end else begin : g_neg
            always_ff @(negedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    cnt_q <= '0;
                end else begin
                    cnt_q <= cnt_d;
                end
            end
        end
    endgenerate

    assign cnt_o = cnt_q;

endmodule

// File: rtl/eeg_loader.sv
// Streams one epoch of ADC samples into int-res memory through a single-entry
// holding register, converting each sample to double-width fixed point.
module eeg_loader
    import eeg_loader_pkg::*;
#(
    parameter int          NUM_SAMPLES = NUM_PATCHES * PATCH_LEN,
    parameter IntResAddr_t BASE_ADDR   = mem_map[EEG_INPUT_MEM],
    localparam int         CNT_W       = $clog2(NUM_SAMPLES + 1)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic            abort,
    input  logic            adc_valid,
    input  AdcData_t        adc_data,
    output logic            adc_ready,
    output logic            mem_wr_en,
    input  logic            mem_wr_grant,
    output IntResAddr_t     mem_wr_addr,
    output IntResDouble_t   mem_wr_data,
    output DataWidth_t      mem_wr_width,
    output FxFormatIntRes_t mem_wr_format,
    output logic            busy,
    output logic            done,
    output logic [CNT_W-1:0] sample_cnt
);

    localparam logic [CNT_W:0]   NUM_EXT  = (CNT_W + 1)'(NUM_SAMPLES);
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NUM_SAMPLES - 1);

    EegLoaderState_t state_q, state_d;
    logic            hold_full_q, hold_full_d;
    AdcData_t        hold_data_q, hold_data_d;
    logic            accept;
    logic            grant_fire;
    logic            cnt_clr;
    logic [CNT_W:0]  in_flight;

    // Samples already committed to this epoch: written ones plus the one waiting in the holding register.
    assign in_flight  = {1'b0, sample_cnt} + {{CNT_W{1'b0}}, hold_full_q};
    assign grant_fire = hold_full_q && mem_wr_grant;
    assign adc_ready  = (state_q == LOAD) && (!hold_full_q || mem_wr_grant) && (in_flight < NUM_EXT);
    assign accept     = adc_valid && adc_ready;

    always_comb begin
        state_d     = state_q;
        hold_full_d = hold_full_q;
        hold_data_d = hold_data_q;
        cnt_clr     = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start && !abort) begin
                    state_d     = LOAD;
                    hold_full_d = 1'b0;
                    cnt_clr     = 1'b1;
                end
            end
            LOAD: begin
                if (abort) begin
                    state_d     = IDLE;
                    hold_full_d = 1'b0;
                end else begin
                    // A same-cycle accept refills the register that the grant just drained.
                    if (accept) begin
                        hold_full_d = 1'b1;
                        hold_data_d = adc_data;
                    end else if (grant_fire) begin
                        hold_full_d = 1'b0;
                    end
                    if (grant_fire && (sample_cnt == LAST_IDX)) begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                state_d     = IDLE;
                hold_full_d = 1'b0;
            end
            default: begin
                state_d     = IDLE;
                hold_full_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            hold_full_q <= 1'b0;
            hold_data_q <= '0;
        end else begin
            state_q     <= state_d;
            hold_full_q <= hold_full_d;
            hold_data_q <= hold_data_d;
        end
    end

    eeg_loader_counter #(
        .WIDTH (CNT_W),
        .MODE  (POSEDGE_TRIGGERED)
    ) u_sample_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr_i (cnt_clr),
        .inc_i (grant_fire),
        .cnt_o (sample_cnt)
    );

    assign mem_wr_en     = hold_full_q;
    assign mem_wr_addr   = BASE_ADDR + IntResAddr_t'(sample_cnt);
    assign mem_wr_data   = adc_to_int_res(hold_data_q);
    assign mem_wr_width  = DOUBLE_WIDTH;
    assign mem_wr_format = int_res_format[EEG_FORMAT];
    assign busy          = (state_q != IDLE);
    assign done          = (state_q == DONE);

endmodule

// File: tb/tb_eeg_loader.sv
// Randomised bench for eeg_loader: a queue-based model of the epoch is compared
// against the DUT every cycle, with literal checks at the interesting corners.
module tb_eeg_loader;
    import eeg_loader_pkg::*;

    localparam int N  = NUM_PATCHES * PATCH_LEN;
    localparam int CW = $clog2(N + 1);

    logic            clk = 1'b0;
    logic            rst_n;
    logic            start;
    logic            abort;
    logic            adc_valid;
    AdcData_t        adc_data;
    logic            adc_ready;
    logic            mem_wr_en;
    logic            mem_wr_grant;
    IntResAddr_t     mem_wr_addr;
    IntResDouble_t   mem_wr_data;
    DataWidth_t      mem_wr_width;
    FxFormatIntRes_t mem_wr_format;
    logic            busy;
    logic            done;
    logic [CW-1:0]   sample_cnt;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    // Model: epoch flags, count of completed writes, and samples accepted but not yet written.
    bit       mActive = 1'b0;
    bit       mDone = 1'b0;
    int       mCount = 0;
    AdcData_t mQ[$];

    int wrCount = 0;
    int doneCount = 0;
    int firstGrantCyc = 0;
    int lastGrantCyc = 0;
    int doneCyc = 0;
    int stallLeft = 0;

    eeg_loader dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .start         (start),
        .abort         (abort),
        .adc_valid     (adc_valid),
        .adc_data      (adc_data),
        .adc_ready     (adc_ready),
        .mem_wr_en     (mem_wr_en),
        .mem_wr_grant  (mem_wr_grant),
        .mem_wr_addr   (mem_wr_addr),
        .mem_wr_data   (mem_wr_data),
        .mem_wr_width  (mem_wr_width),
        .mem_wr_format (mem_wr_format),
        .busy          (busy),
        .done          (done),
        .sample_cnt    (sample_cnt)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input bit s, input bit a, input bit v, input AdcData_t d, input bit g);
        start        = s;
        abort        = a;
        adc_valid    = v;
        adc_data     = d;
        mem_wr_grant = g;
    endtask

    function automatic AdcData_t rnd();
        return AdcData_t'($urandom);
    endfunction

    // Compare process: expected outputs come from the model, then the model advances one clock.
    always @(negedge clk) begin : cmp
        bit expEn;
        bit expReady;
        bit granted;
        bit accepted;
        if (!rst_n) begin
            mActive = 1'b0;
            mDone   = 1'b0;
            mCount  = 0;
            mQ.delete();
            checkOutput("rst_ready", 32'(adc_ready), 32'd0);
            checkOutput("rst_wr_en", 32'(mem_wr_en), 32'd0);
            checkOutput("rst_addr", 32'(mem_wr_addr), 32'(mem_map[EEG_INPUT_MEM]));
            checkOutput("rst_data", 32'(mem_wr_data), 32'd0);
            checkOutput("rst_busy", 32'(busy), 32'd0);
            checkOutput("rst_done", 32'(done), 32'd0);
            checkOutput("rst_cnt", 32'(sample_cnt), 32'd0);
        end else begin
            expEn    = (mQ.size() > 0);
            expReady = mActive && (!expEn || mem_wr_grant) && ((mCount + mQ.size()) < N);
            checkOutput("ready", 32'(adc_ready), 32'(expReady));
            checkOutput("wr_en", 32'(mem_wr_en), 32'(expEn));
            checkOutput("addr", 32'(mem_wr_addr), 32'(mem_map[EEG_INPUT_MEM]) + 32'(mCount));
            if (expEn) checkOutput("data", 32'(mem_wr_data), 32'(mQ[0]) * 32'd16);
            checkOutput("busy", 32'(busy), 32'(mActive || mDone));
            checkOutput("done", 32'(done), 32'(mDone));
            checkOutput("cnt", 32'(sample_cnt), 32'(mCount));

            if (mem_wr_en && mem_wr_grant) begin
                if (wrCount == 0) firstGrantCyc = cyc;
                lastGrantCyc = cyc;
                wrCount++;
            end
            if (done) begin
                doneCount++;
                doneCyc = cyc;
            end

            granted  = expEn && mem_wr_grant;
            accepted = adc_valid && expReady;
            if (granted) begin
                void'(mQ.pop_front());
                mCount++;
            end
            if (abort && (mActive || mDone)) begin
                mActive = 1'b0;
                mDone   = 1'b0;
                mQ.delete();
            end else if (mDone) begin
                mDone = 1'b0;
            end else if (mActive) begin
                if (accepted) mQ.push_back(adc_data);
                if (mCount == N) begin
                    mActive = 1'b0;
                    mDone   = 1'b1;
                end
            end else if (start && !abort) begin
                mActive = 1'b1;
                mCount  = 0;
                mQ.delete();
            end
        end
    end

    initial begin
        rst_n = 1'b0;
        applyStimulus(0, 0, 0, '0, 0);
        #3;
        checkOutput("reset_ready", 32'(adc_ready), 32'd0);
        checkOutput("reset_busy", 32'(busy), 32'd0);
        checkOutput("reset_addr", 32'(mem_wr_addr), 32'd0);
        checkOutput("reset_data", 32'(mem_wr_data), 32'd0);
        checkOutput("reset_cnt", 32'(sample_cnt), 32'd0);
        checkOutput("width", 32'(mem_wr_width), 32'(DOUBLE_WIDTH));
        checkOutput("format", 32'(mem_wr_format), 32'(INT_RES_DW_FX));
        nextCycle();
        nextCycle();
        rst_n = 1'b1;

        // adc_valid while idle must be ignored
        for (int i = 0; i < 5; i++) begin
            nextCycle();
            applyStimulus(0, 0, 1, rnd(), 1);
            #2;
            checkOutput("idle_ready", 32'(adc_ready), 32'd0);
            checkOutput("idle_wr_en", 32'(mem_wr_en), 32'd0);
        end

        // Full-rate epoch with conversion corners on the first two samples
        wrCount = 0; doneCount = 0;
        nextCycle(); applyStimulus(1, 0, 1, 16'hFFFF, 1);
        nextCycle(); applyStimulus(0, 0, 1, 16'hFFFF, 1);
        nextCycle(); applyStimulus(0, 0, 1, 16'h0000, 1);
        #2;
        checkOutput("ffff_data", 32'(mem_wr_data), 32'h000FFFF0);
        checkOutput("ffff_addr", 32'(mem_wr_addr), 32'd0);
        nextCycle(); applyStimulus(0, 0, 1, rnd(), 1);
        #2;
        checkOutput("zero_data", 32'(mem_wr_data), 32'd0);
        checkOutput("zero_addr", 32'(mem_wr_addr), 32'd1);
        for (int i = 0; i < 5000; i++) begin
            nextCycle();
            if (!mActive && !mDone) break;
            applyStimulus(0, 0, 1, rnd(), 1);
        end
        checkOutput("full_timeout", 32'(mActive || mDone), 32'd0);
        applyStimulus(0, 0, 0, '0, 0);
        nextCycle();
        checkOutput("full_writes", 32'(wrCount), 32'(N));
        checkOutput("full_span", 32'(lastGrantCyc - firstGrantCyc), 32'(N - 1));
        checkOutput("full_done_cnt", 32'(doneCount), 32'd1);
        checkOutput("full_done_cyc", 32'(doneCyc), 32'(lastGrantCyc + 1));

        // Random valid/grant, a 5-cycle grant stall at sample 10, and starts while busy
        wrCount = 0; doneCount = 0; stallLeft = 5;
        nextCycle(); applyStimulus(1, 0, 1, rnd(), 1);
        for (int i = 0; i < 20000; i++) begin
            bit g;
            bit v;
            bit s;
            nextCycle();
            if (!mActive && !mDone) break;
            g = ($urandom_range(3) != 0);
            v = ($urandom_range(3) != 0);
            s = (i == 50) || (i == 200) || (i == 1000);
            if (mCount == 10 && mQ.size() > 0 && stallLeft > 0) begin
                stallLeft--;
                applyStimulus(s, 0, 1, rnd(), 0);
                #2;
                checkOutput("stall_addr", 32'(mem_wr_addr), 32'd10);
                checkOutput("stall_en", 32'(mem_wr_en), 32'd1);
                checkOutput("stall_ready", 32'(adc_ready), 32'd0);
            end else begin
                applyStimulus(s, 0, v, rnd(), g);
            end
        end
        checkOutput("rand_timeout", 32'(mActive || mDone), 32'd0);
        applyStimulus(0, 0, 0, '0, 0);
        nextCycle();
        checkOutput("rand_stall_seen", 32'(stallLeft), 32'd0);
        checkOutput("rand_writes", 32'(wrCount), 32'(N));
        checkOutput("rand_done_cnt", 32'(doneCount), 32'd1);

        // Abort at sample_cnt = 100, then restart from address 0
        doneCount = 0;
        nextCycle(); applyStimulus(1, 0, 1, rnd(), 1);
        for (int i = 0; i < 1000; i++) begin
            nextCycle();
            if (mCount == 100 && mQ.size() > 0) break;
            applyStimulus(0, 0, 1, rnd(), 1);
        end
        applyStimulus(0, 1, 1, rnd(), 0);
        #2;
        checkOutput("abort_at_cnt", 32'(sample_cnt), 32'd100);
        nextCycle(); applyStimulus(0, 0, 1, rnd(), 1);
        #2;
        checkOutput("abort_wr_en", 32'(mem_wr_en), 32'd0);
        checkOutput("abort_busy", 32'(busy), 32'd0);
        checkOutput("abort_ready", 32'(adc_ready), 32'd0);
        checkOutput("abort_cnt_kept", 32'(sample_cnt), 32'd100);
        for (int i = 0; i < 3; i++) begin
            nextCycle(); applyStimulus(0, 0, 1, rnd(), 1);
        end
        checkOutput("abort_no_done", 32'(doneCount), 32'd0);
        nextCycle(); applyStimulus(1, 0, 1, rnd(), 1);
        nextCycle(); applyStimulus(0, 0, 1, rnd(), 1);
        #2;
        checkOutput("restart_addr", 32'(mem_wr_addr), 32'd0);
        checkOutput("restart_cnt", 32'(sample_cnt), 32'd0);
        checkOutput("restart_busy", 32'(busy), 32'd1);

        // Asynchronous reset between clock edges mid-epoch
        for (int i = 0; i < 40; i++) begin
            nextCycle(); applyStimulus(0, 0, 1, rnd(), $urandom_range(1) == 1);
        end
        applyStimulus(0, 0, 1, rnd(), 1);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        checkOutput("async_ready", 32'(adc_ready), 32'd0);
        checkOutput("async_wr_en", 32'(mem_wr_en), 32'd0);
        checkOutput("async_busy", 32'(busy), 32'd0);
        checkOutput("async_done", 32'(done), 32'd0);
        checkOutput("async_addr", 32'(mem_wr_addr), 32'd0);
        checkOutput("async_data", 32'(mem_wr_data), 32'd0);
        checkOutput("async_cnt", 32'(sample_cnt), 32'd0);
        wrCount = 0;
        nextCycle();
        nextCycle();
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            nextCycle(); applyStimulus(0, 0, 1, rnd(), 1);
            #2;
            checkOutput("post_rst_ready", 32'(adc_ready), 32'd0);
        end
        checkOutput("post_rst_writes", 32'(wrCount), 32'd0);

        // Random soak including aborts that may coincide with grants
        for (int i = 0; i < 3000; i++) begin
            nextCycle();
            applyStimulus($urandom_range(99) == 0, $urandom_range(299) == 0,
                          $urandom_range(3) != 0, rnd(), $urandom_range(3) != 0);
        end
        applyStimulus(0, 0, 0, '0, 0);
        nextCycle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #600000;
        errors++;
        $display("[TB] FAIL watchdog: simulation did not complete in time");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
